// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: add/sub/and/or/slt with Zero and Overflow flags, registered
// behind a valid/ready handshake with a 2-entry skid buffer (main M drives outputs, S absorbs stalls).
module alu_exec_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       AluControl,
    input  logic [4:0]       InDst,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] AluResult,
    output logic             Zero,
    output logic             Overflow,
    output logic [4:0]       OutDst
);

    localparam int unsigned MSB     = WIDTH - 1;
    localparam int unsigned ENTRY_W = WIDTH + 7;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [WIDTH-1:0]   sum_c, diff_c, res_c;
    logic               ovf_add_c, ovf_sub_c, ovf_c, lt_c, zero_c;
    logic [ENTRY_W-1:0] new_entry_c;

    logic               m_valid_q, m_valid_d;
    logic               s_valid_q, s_valid_d;
    logic [ENTRY_W-1:0] m_data_q, m_data_d;
    logic [ENTRY_W-1:0] s_data_q, s_data_d;
    logic               in_ready_q, in_ready_d;
    logic               accept_c, pop_c;

    // Input-side compute; an entry is {result, zero, overflow, dst}.
    always_comb begin
        sum_c     = SrcA + SrcB;
        diff_c    = SrcA - SrcB;
        ovf_add_c = (SrcA[MSB] == SrcB[MSB]) && (sum_c[MSB] != SrcA[MSB]);
        ovf_sub_c = (SrcA[MSB] != SrcB[MSB]) && (diff_c[MSB] != SrcA[MSB]);
        lt_c      = diff_c[MSB] ^ ovf_sub_c;
        res_c     = '0;
        ovf_c     = 1'b0;
        case (AluControl)
            OP_ADD: begin
                res_c = sum_c;
                ovf_c = ovf_add_c;
            end
            OP_SUB: begin
                res_c = diff_c;
                ovf_c = ovf_sub_c;
            end
            OP_AND: res_c = SrcA & SrcB;
            OP_OR:  res_c = SrcA | SrcB;
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, lt_c};
            default: begin
                res_c = '0;
                ovf_c = 1'b0;
            end
        endcase
        zero_c      = (res_c == '0);
        new_entry_c = {res_c, zero_c, ovf_c, InDst};
    end

    assign accept_c = InValid & in_ready_q;
    assign pop_c    = m_valid_q & OutReady;

    // Skid-buffer next state; S always drains into M before new data is taken.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        if (s_valid_q) begin
            if (pop_c) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end
        end else if (!m_valid_q) begin
            if (accept_c) begin
                m_data_d  = new_entry_c;
                m_valid_d = 1'b1;
            end
        end else if (pop_c && accept_c) begin
            m_data_d = new_entry_c;
        end else if (pop_c) begin
            m_valid_d = 1'b0;
        end else if (accept_c) begin
            s_data_d  = new_entry_c;
            s_valid_d = 1'b1;
        end
        if (Flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            m_data_q   <= '0;
            s_data_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            m_data_q   <= m_data_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign InReady   = in_ready_q;
    assign OutValid  = m_valid_q;
    assign AluResult = m_data_q[ENTRY_W-1 -: WIDTH];
    assign Zero      = m_data_q[6];
    assign Overflow  = m_data_q[5];
    assign OutDst    = m_data_q[4:0];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: inputs driven and outputs sampled on the falling edge.
module tb_alu_exec_stage;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset, Flush, InValid, InReady, OutValid, OutReady, Zero, Overflow;
    logic [WIDTH-1:0] SrcA, SrcB, AluResult;
    logic [2:0]       AluControl;
    logic [4:0]       InDst, OutDst;

    int n_vec = 0;
    int n_err = 0;

    alu_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .SrcA(SrcA), .SrcB(SrcB), .AluControl(AluControl), .InDst(InDst),
        .OutValid(OutValid), .OutReady(OutReady),
        .AluResult(AluResult), .Zero(Zero), .Overflow(Overflow), .OutDst(OutDst)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst);
        InValid    = 1'b1;
        AluControl = op;
        SrcA       = a;
        SrcB       = b;
        InDst      = dst;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic z,
                             input logic ovf, input logic [4:0] dst);
        check_val({tag, ".valid"}, 32'(OutValid), 32'd1);
        check_val({tag, ".res"}, AluResult, res);
        check_val({tag, ".zero"}, 32'(Zero), 32'(z));
        check_val({tag, ".ovf"}, 32'(Overflow), 32'(ovf));
        check_val({tag, ".dst"}, 32'(OutDst), 32'(dst));
    endtask

    // Issue one op at OutReady=1 and check it exactly one cycle later.
    task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] dst,
                            input logic [31:0] res, input logic z, input logic ovf);
        OutReady = 1'b1;
        drive(op, a, b, dst);
        @(negedge clk);
        check_out(tag, res, z, ovf, dst);
        InValid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        SrcA = '0; SrcB = '0; AluControl = 3'b000; InDst = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            check_val("idle.valid", 32'(OutValid), 32'd0);
            check_val("idle.ready", 32'(InReady), 32'd1);
            check_val("idle.res", AluResult, 32'd0);
            @(negedge clk);
        end

        op_check("add", 3'b010, 32'd7, 32'd5, 5'd11, 32'd12, 1'b0, 1'b0);
        op_check("sub0", 3'b110, 32'd5, 32'd5, 5'd12, 32'd0, 1'b1, 1'b0);
        op_check("and", 3'b000, 32'hF0F0, 32'h0FF0, 5'd13, 32'h00F0, 1'b0, 1'b0);
        op_check("or", 3'b001, 32'hF000, 32'h000F, 5'd14, 32'hF00F, 1'b0, 1'b0);
        op_check("subneg", 3'b110, 32'd3, 32'd7, 5'd15, 32'hFFFF_FFFC, 1'b0, 1'b0);
        op_check("addovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 5'd16, 32'h8000_0000, 1'b0, 1'b1);
        op_check("subovf", 3'b110, 32'h8000_0000, 32'd1, 5'd17, 32'h7FFF_FFFF, 1'b0, 1'b1);
        op_check("slt1", 3'b111, 32'hFFFF_FFFF, 32'd1, 5'd18, 32'd1, 1'b0, 1'b0);
        op_check("slt2", 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd19, 32'd1, 1'b0, 1'b0);
        op_check("slt3", 3'b111, 32'd5, 32'hFFFF_FFFD, 5'd20, 32'd0, 1'b1, 1'b0);
        op_check("op100", 3'b100, 32'h7FFF_FFFF, 32'd1, 5'd21, 32'd0, 1'b1, 1'b0);
        op_check("op011", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("drain.valid", 32'(OutValid), 32'd0);

        // Backpressure: tags 1,2,3 with OutReady low.
        OutReady = 1'b0;
        drive(3'b010, 32'd1, 32'd1, 5'd1);
        @(negedge clk);
        check_out("bp.m1", 32'd2, 1'b0, 1'b0, 5'd1);
        check_val("bp.ready1", 32'(InReady), 32'd1);
        drive(3'b010, 32'd2, 32'd2, 5'd2);
        @(negedge clk);
        check_val("bp.ready0", 32'(InReady), 32'd0);
        drive(3'b010, 32'd3, 32'd3, 5'd3);
        for (int i = 0; i < 3; i++) begin
            check_out("bp.hold", 32'd2, 1'b0, 1'b0, 5'd1);
            check_val("bp.stall_ready", 32'(InReady), 32'd0);
            @(negedge clk);
        end
        OutReady = 1'b1;
        @(negedge clk);
        check_out("bp.t2", 32'd4, 1'b0, 1'b0, 5'd2);
        check_val("bp.ready_back", 32'(InReady), 32'd1);
        @(negedge clk);
        check_out("bp.t3", 32'd6, 1'b0, 1'b0, 5'd3);
        InValid = 1'b0;
        @(negedge clk);
        check_val("bp.empty", 32'(OutValid), 32'd0);

        // Simultaneous pop and accept with M full, S empty.
        OutReady = 1'b0;
        drive(3'b001, 32'hF0, 32'h0F, 5'd4);
        @(negedge clk);
        check_out("pa.m4", 32'hFF, 1'b0, 1'b0, 5'd4);
        OutReady = 1'b1;
        drive(3'b110, 32'd10, 32'd3, 5'd5);
        @(negedge clk);
        check_out("pa.m5", 32'd7, 1'b0, 1'b0, 5'd5);
        check_val("pa.ready", 32'(InReady), 32'd1);
        InValid = 1'b0;
        @(negedge clk);
        check_val("pa.empty", 32'(OutValid), 32'd0);

        // Flush with M and S full while an op is offered.
        OutReady = 1'b0;
        drive(3'b010, 32'd6, 32'd0, 5'd6);
        @(negedge clk);
        drive(3'b010, 32'd7, 32'd0, 5'd7);
        @(negedge clk);
        check_val("fl.full_ready", 32'(InReady), 32'd0);
        check_val("fl.full_valid", 32'(OutValid), 32'd1);
        Flush = 1'b1;
        drive(3'b010, 32'd8, 32'd0, 5'd8);
        @(negedge clk);
        Flush = 1'b0;
        InValid = 1'b0;
        check_val("fl.valid", 32'(OutValid), 32'd0);
        check_val("fl.ready", 32'(InReady), 32'd1);
        OutReady = 1'b1;
        @(negedge clk);
        check_val("fl.no_trace", 32'(OutValid), 32'd0);
        op_check("fl.next", 3'b010, 32'd100, 32'd23, 5'd9, 32'd123, 1'b0, 1'b0);
        @(negedge clk);
        check_val("fl.empty", 32'(OutValid), 32'd0);

        // Reset mid-stall clears valids and data.
        OutReady = 1'b0;
        drive(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd10);
        @(negedge clk);
        drive(3'b000, 32'd1, 32'd1, 5'd30);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        InValid = 1'b0;
        check_val("rs.valid", 32'(OutValid), 32'd0);
        check_val("rs.ready", 32'(InReady), 32'd1);
        check_val("rs.res", AluResult, 32'd0);
        check_val("rs.ovf", 32'(Overflow), 32'd0);
        check_val("rs.dst", 32'(OutDst), 32'd0);
        @(negedge clk);
        check_val("rs.stay_empty", 32'(OutValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
